fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin write arbiter sharing one synchronous FIFO write port between NUM_REQ producers.
//  - Accepts one word per cycle via per-requester valid/ready (req/gnt).
//  - Drives the FIFO wr_en/data_in with one registered stage.
//  - Throttles on full/almostfull so the FIFO never overflows.
//  - Checks the FIFO's wr_ack/overflow responses.
//  Sits between producer clients and the FIFO write side.
// PARAMETERS
//  NUM_REQ     4   number of requesters (2..8)
//  DATA_WIDTH  16  FIFO word width
// PORTS
//  clk           in   1                  clock, all logic on posedge
//  rst           in   1                  asynchronous reset, active-high
//  req           in   NUM_REQ            req[i]=1: req_data slice i valid, held until gnt[i]
//  req_data      in   NUM_REQ*DATA_WIDTH slice i = bits [i*DATA_WIDTH +: DATA_WIDTH]
//  gnt           out  NUM_REQ            one-hot combinational accept; transfer when req[i]&gnt[i]
//  fifo_wr_en    out  1                  registered FIFO write enable
//  fifo_data_in  out  DATA_WIDTH         registered FIFO write data
//  fifo_full     in   1                  FIFO full flag
//  fifo_almostfull in 1                  FIFO count == FIFO_DEPTH-1
//  fifo_wr_ack   in   1                  FIFO write acknowledge, one cycle after wr_en
//  fifo_overflow in   1                  FIFO overflow flag
//  arb_stall     out  1                  1 while in STALL state
//  err_ack       out  1                  sticky: wr_en issued, no wr_ack next cycle
//  err_ovf       out  1                  sticky: fifo_overflow seen
// BEHAVIOUR
//  - Reset: all outputs 0; rr_ptr=0; state=IDLE.
//    - gnt is forced 0 combinationally while rst=1.
//    - Reset mid-transfer drops the in-flight word. No replay.
//  - can_issue = !fifo_full && !(fifo_wr_en && fifo_almostfull).
//    - Conservative: ignores concurrent reads.
//  - Pick: the first i with req[i]=1, scanning from rr_ptr upward, mod NUM_REQ.
//    - gnt[pick] = can_issue && |req.
//  - Posedge after a grant:
//    - fifo_wr_en <= 1 and fifo_data_in <= req_data[pick].
//    - rr_ptr <= pick+1, wrapping NUM_REQ-1 -> 0.
//    - Latency from accept to fifo_wr_en is 1 cycle. Throughput is 1 word/cycle.
//  - No grant: fifo_wr_en <= 0; fifo_data_in holds its value; rr_ptr holds.
//  - Fairness: with every req high, grants rotate 0,1,..,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 grants.
//  - FSM (registered, from fsm_state_t):
//    - IDLE:   no req.        -> ACTIVE if |req && can_issue; -> STALL if |req && !can_issue.
//    - ACTIVE: granting.      -> STALL if !can_issue && |req; -> IDLE if !|req.
//    - STALL:  gnt=0, arb_stall=1. -> ACTIVE when can_issue && |req; -> IDLE if !|req.
//  - Ack check: ack_pend <= fifo_wr_en.
//    - err_ack sets if ack_pend && !fifo_wr_ack.
//    - err_ovf sets on fifo_overflow.
//    - Both clear only on rst.
//  - A requester dropping req without gnt is legal. The word is simply not taken.
// CONFIGURATION
//  - FIFO_ARB_STATS_EN defined:
//    - Adds output grant_cnt (NUM_REQ*16 bits): per-requester grants, saturating at 16'hFFFF.
//    - Adds output stall_cnt (16 bits): STALL cycles, saturating.
//    - All counters reset to 0.
//  - Undefined: those ports and counters do not exist. Behaviour is otherwise identical.
// STRUCTURE
//  - fifo_arb_pkg:
//    - fsm_state_t enum {IDLE, ACTIVE, STALL}.
//    - CNT_W = 16 and CNT_MAX constants.
//    - function rr_pick(req, ptr) returning the index and a found bit.
//  - Sub-module fifo_rr_pick: combinational rotating-priority picker (req, rr_ptr -> pick, found).
//    - Instantiated once.
//  - Top level holds the FSM, output registers, error flags and optional counters.
// TESTING
//  - Reset: assert rst mid-stream with req=4'b1111.
//    - gnt=0 and fifo_wr_en=0 immediately; rr_ptr=0.
//    - After release, the first grant goes to req0.
//  - Round-robin: req=4'b1111 held for 8 cycles, FIFO empty.
//    - Grants 0,1,2,3,0,1,2,3.
//    - fifo_data_in follows the req_data slices, one cycle later.
//  - Sparse: req=4'b1010, rr_ptr=0.
//    - Grant 1, then 3, then 1.
//    - Requesters 0 and 2 are never granted.
//  - Backpressure, FIFO_DEPTH=8:
//    - Fill to count=7 (almostfull=1) with a write in flight.
//    - gnt=0 and STALL.
//    - No overflow. err_ovf stays 0.
//    - One read then resumes grants.
//  - Ack fault: FIFO model suppresses wr_ack after one write.
//    - err_ack=1 the next cycle and stays 1 until rst.
//  - Stats (FIFO_ARB_STATS_EN): 10 grants to req2 and 3 stall cycles.
//    - grant_cnt[2]=10, stall_cnt=3.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
// Provides the FSM state type, the statistics counter width and the rotating-priority search.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2
    } fsm_state_t;

    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    // Widest supported requester set; the pointer is sized for it.
    localparam int MAX_REQ = 8;
    localparam int PTR_W   = 3;

    typedef struct packed {
        logic             found;
        logic [PTR_W-1:0] idx;
    } pick_t;

    // Return the first set bit of req at or above ptr, wrapping modulo n.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [PTR_W-1:0]   ptr,
                                      input int                 n);
        pick_t res;
        int    j;
        res = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) j = j - n;
                if (!res.found && req[j[PTR_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = PTR_W'(j);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-write-side bundle of the arbiter.
// master: the arbiter's view; slave: the producers + FIFO environment.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_data_in;
    logic                          fifo_full;
    logic                          fifo_almostfull;
    logic                          fifo_wr_ack;
    logic                          fifo_overflow;
    logic                          arb_stall;
    logic                          err_ack;
    logic                          err_ovf;

    modport master (
        input  req, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
        output gnt, fifo_wr_en, fifo_data_in, arb_stall, err_ack, err_ovf
    );

    modport slave (
        output req, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
        input  gnt, fifo_wr_en, fifo_data_in, arb_stall, err_ack, err_ovf
    );
endinterface

// File: rtl/fifo_rr_pick.sv
// Combinational rotating-priority picker: first requester at or after ptr_i.
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [PTR_W-1:0]   pick_o,
    output logic               found_o
);
    logic [MAX_REQ-1:0] req_ext;
    pick_t              res;

    // Widen the request vector and run the shared search.
    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req_i;
        res                    = rr_pick(req_ext, ptr_i, NUM_REQ);
        pick_o                 = res.idx;
        found_o                = res.found;
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// One registered stage to the FIFO; throttles on full/almostfull; sticky ack/overflow errors.
// Optional build macro FIFO_ARB_STATS_EN adds saturating grant_cnt / stall_cnt outputs.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    fifo_wr_arbiter_if.master        bus
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0] grant_cnt,
    output logic [CNT_W-1:0]         stall_cnt
`endif
);
    fsm_state_t            state_q, state_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  wr_en_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  ack_pend_q;
    logic                  err_ack_q;
    logic                  err_ovf_q;

    logic [PTR_W-1:0]      pick;
    logic                  found;
    logic                  any_req;
    logic                  can_issue;
    logic                  grant;
    logic [DATA_WIDTH-1:0] sel_data;

    fifo_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i   (bus.req),
        .ptr_i   (rr_ptr_q),
        .pick_o  (pick),
        .found_o (found)
    );

    // A write already in flight into a FIFO one slot short of full would fill it,
    // so that case blocks a new grant. Concurrent reads are not credited.
    assign any_req   = |bus.req;
    assign can_issue = !bus.fifo_full && !(wr_en_q && bus.fifo_almostfull);
    assign grant     = can_issue && found && !rst;

    // One-hot accept and selected data slice.
    always_comb begin
        bus.gnt  = grant ? (NUM_REQ'(1) << pick) : '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == PTR_W'(i)) sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Next FSM state and round-robin pointer.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = can_issue ? ACTIVE : STALL;
            ACTIVE:  if (!any_req) state_d = IDLE;
                     else if (!can_issue) state_d = STALL;
            STALL:   if (!any_req) state_d = IDLE;
                     else if (can_issue) state_d = ACTIVE;
            default: state_d = IDLE;
        endcase
        if (grant) rr_ptr_d = (pick == PTR_W'(NUM_REQ-1)) ? '0 : pick + 1'b1;
    end

    // Registered FIFO drive, FSM, pointer and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            wr_en_q    <= 1'b0;
            data_q     <= '0;
            ack_pend_q <= 1'b0;
            err_ack_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_en_q    <= grant;
            if (grant) data_q <= sel_data;
            ack_pend_q <= wr_en_q;
            if (ack_pend_q && !bus.fifo_wr_ack) err_ack_q <= 1'b1;
            if (bus.fifo_overflow) err_ovf_q <= 1'b1;
        end
    end

    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_data_in = data_q;
    assign bus.arb_stall    = (state_q == STALL);
    assign bus.err_ack      = err_ack_q;
    assign bus.err_ovf      = err_ovf_q;

`ifdef FIFO_ARB_STATS_EN
    logic [CNT_W-1:0] grant_cnt_q [NUM_REQ];
    logic [CNT_W-1:0] stall_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Saturating per-requester grant and stall-cycle counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant && pick == PTR_W'(i)) grant_cnt_q[i] <= sat_inc(grant_cnt_q[i]);
            end
            if (state_q == STALL) stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*CNT_W +: CNT_W] = grant_cnt_q[i];
    end
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: 4 requesters, 16-bit data, depth-8 FIFO model.
module tb_fifo_wr_arbiter;
    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

`ifdef FIFO_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
    logic [15:0]     stall_cnt;
`endif

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FIFO_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    // FIFO write-side model
    int   fcnt      = 0;
    logic ack_r     = 1'b0;
    logic ovf_r     = 1'b0;
    logic fifo_rd   = 1'b0;
    logic fifo_clr  = 1'b0;
    logic kill_ack  = 1'b0;
    logic force_ovf = 1'b0;

    always @(posedge clk) begin
        if (fifo_clr) begin
            fcnt  <= 0;
            ack_r <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            fcnt  <= fcnt + ((bus.fifo_wr_en && fcnt < DEPTH) ? 1 : 0)
                          - ((fifo_rd && fcnt > 0) ? 1 : 0);
            ack_r <= bus.fifo_wr_en && !kill_ack;
            ovf_r <= (bus.fifo_wr_en && fcnt == DEPTH) || force_ovf;
        end
    end

    assign bus.fifo_full       = (fcnt == DEPTH);
    assign bus.fifo_almostfull = (fcnt == DEPTH - 1);
    assign bus.fifo_wr_ack     = ack_r;
    assign bus.fifo_overflow   = ovf_r;

    // Reference model state
    int            m_ptr;
    logic          m_wr_en;
    logic [DW-1:0] m_data;
    logic          m_stall;
    logic          m_ack_pend;
    logic          m_err_ack;
    logic          m_err_ovf;
    int            m_gcnt [N];
    int            m_scnt;

    logic          lit_en  = 1'b0;
    logic [N-1:0]  lit_gnt = '0;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr      = 0;
        m_wr_en    = 1'b0;
        m_data     = '0;
        m_stall    = 1'b0;
        m_ack_pend = 1'b0;
        m_err_ack  = 1'b0;
        m_err_ovf  = 1'b0;
        m_scnt     = 0;
        for (int i = 0; i < N; i++) m_gcnt[i] = 0;
    endtask

    // Called just after a posedge; leaves the bench just after the next one.
    task automatic do_reset();
        rst      = 1'b1;
        fifo_clr = 1'b1;
        #1;
        chk("rst_gnt",     bus.gnt,          0);
        chk("rst_wr_en",   bus.fifo_wr_en,   0);
        chk("rst_data",    bus.fifo_data_in, 0);
        chk("rst_stall",   bus.arb_stall,    0);
        chk("rst_err_ack", bus.err_ack,      0);
        chk("rst_err_ovf", bus.err_ovf,      0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_gnt_held", bus.gnt, 0);
        rst      = 1'b0;
        fifo_clr = 1'b0;
    endtask

    // One clock of stimulus with model prediction and checks.
    task automatic run_cycle(input logic [N-1:0] r, input logic rd);
        logic [N-1:0]  exp_gnt;
        logic          can, any, ack_s, ovf_s;
        logic [DW-1:0] d;
        int            pk, idx;
        bus.req = r;
        fifo_rd = rd;
        for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = DW'($urandom);
        #3;
        can = !bus.fifo_full && !(m_wr_en && bus.fifo_almostfull);
        any = |r;
        pk  = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (pk < 0 && r[idx]) pk = idx;
        end
        exp_gnt = '0;
        d       = '0;
        if (can && pk >= 0) begin
            exp_gnt[pk] = 1'b1;
            d = bus.req_data[pk*DW +: DW];
        end
        chk("gnt",   bus.gnt,       exp_gnt);
        chk("stall", bus.arb_stall, m_stall);
        if (lit_en) chk("gnt_seq", bus.gnt, lit_gnt);
        ack_s = bus.fifo_wr_ack;
        ovf_s = bus.fifo_overflow;
        @(posedge clk);
        #1;
        if (m_ack_pend && !ack_s) m_err_ack = 1'b1;
        if (ovf_s) m_err_ovf = 1'b1;
        m_ack_pend = m_wr_en;
        if (m_stall && m_scnt < 65535) m_scnt++;
        m_stall = any && !can;
        if (exp_gnt != '0) begin
            m_wr_en = 1'b1;
            m_data  = d;
            m_ptr   = (pk + 1) % N;
            if (m_gcnt[pk] < 65535) m_gcnt[pk]++;
        end else begin
            m_wr_en = 1'b0;
        end
        chk("wr_en",   bus.fifo_wr_en,   m_wr_en);
        chk("data",    bus.fifo_data_in, m_data);
        chk("err_ack", bus.err_ack,      m_err_ack);
        chk("err_ovf", bus.err_ovf,      m_err_ovf);
    endtask

    initial begin
        bus.req      = '0;
        bus.req_data = '0;
        model_reset();
        #1;
        do_reset();

        // Full rotation with an almost-empty FIFO
        lit_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            lit_gnt = N'(1) << (k % N);
            run_cycle(4'b1111, 1'b1);
        end
        lit_en = 1'b0;

        // Reset in the middle of a stream: first grant afterwards goes to req0
        run_cycle(4'b1111, 1'b1);
        do_reset();
        lit_en  = 1'b1;
        lit_gnt = 4'b0001;
        run_cycle(4'b1111, 1'b1);
        lit_en  = 1'b0;

        // Sparse requesters 1 and 3
        do_reset();
        lit_en = 1'b1;
        lit_gnt = 4'b0010; run_cycle(4'b1010, 1'b1);
        lit_gnt = 4'b1000; run_cycle(4'b1010, 1'b1);
        lit_gnt = 4'b0010; run_cycle(4'b1010, 1'b1);
        lit_en = 1'b0;

        // Backpressure: fill with no reads, then free one slot
        do_reset();
        for (int k = 0; k < 12; k++) run_cycle(4'b1111, 1'b0);
        chk("bp_fill",   fcnt,          DEPTH);
        chk("bp_stall",  bus.arb_stall, 1);
        chk("bp_no_ovf", bus.err_ovf,   0);
        run_cycle(4'b1111, 1'b1);
        lit_en  = 1'b1;
        lit_gnt = 4'b0001;
        run_cycle(4'b1111, 1'b0);
        lit_en  = 1'b0;
        for (int k = 0; k < 3; k++) run_cycle(4'b1111, 1'b0);
        chk("bp_no_ovf2", bus.err_ovf, 0);

        // Missing write acknowledge
        do_reset();
        run_cycle(4'b0001, 1'b1);
        kill_ack = 1'b1;
        run_cycle(4'b0000, 1'b1);
        kill_ack = 1'b0;
        run_cycle(4'b0000, 1'b1);
        chk("ack_err_set", bus.err_ack, 1);
        for (int k = 0; k < 4; k++) run_cycle(4'b0101, 1'b1);
        chk("ack_err_sticky", bus.err_ack, 1);

        // Overflow flag from the FIFO
        force_ovf = 1'b1;
        run_cycle(4'b0000, 1'b1);
        force_ovf = 1'b0;
        run_cycle(4'b0000, 1'b1);
        run_cycle(4'b0000, 1'b1);
        chk("ovf_err_sticky", bus.err_ovf, 1);

        // Randomized traffic with occasional missing acks
        do_reset();
        for (int k = 0; k < 400; k++) begin
            kill_ack = ($urandom_range(0, 49) == 0);
            run_cycle(N'($urandom), ($urandom_range(0, 9) < 4));
        end
        kill_ack = 1'b0;

`ifdef FIFO_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("grant_cnt", grant_cnt[i*16 +: 16], m_gcnt[i]);
        chk("stall_cnt", stall_cnt, m_scnt);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
